// File: rtl/memoria_param.sv
// memoria_param: parametrised multi-read-port register memory with registered
// reads, per-port valid flags and a post-reset hardware clear sequence.
// Optional build macro: MEMORIA_BYPASS_EN selects write-first behaviour for a
// read that hits the address being written in the same cycle. Without it the
// memory is read-first.
module memoria_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter int NRD    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_valid,
  output logic                  busy
);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  // Depth widened by one bit so that DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;
  logic [ADDR_W-1:0] port_addr [NRD];
  logic [DATA_W-1:0] port_word [NRD];

  assign busy  = (state == CLEAR);
  assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_EXT) && (state == READY);

  // Per-port read word: out-of-range addresses read as zero; the macro decides
  // whether a same-cycle write to the same address is forwarded.
  for (genvar g = 0; g < NRD; g++) begin : g_port
    logic in_range;
    assign port_addr[g] = rd_addr[g*ADDR_W +: ADDR_W];
    assign in_range     = ({1'b0, port_addr[g]} < DEPTH_EXT);
`ifdef MEMORIA_BYPASS_EN
    assign port_word[g] = !in_range ? '0 :
                          (wr_ok && (wr_addr == port_addr[g])) ? wr_data :
                          mem[port_addr[g]];
`else
    assign port_word[g] = in_range ? mem[port_addr[g]] : '0;
`endif
  end

  // Clear sequencer: walk every address once after reset, then stay READY.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      if (clr_cnt == LAST_ADDR) begin
        state   <= READY;
        clr_cnt <= '0;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  // Storage array: zero-filled by the clear walk, otherwise written by wr_en.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[clr_cnt] <= '0;
      end else if (wr_ok) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  // Registered read ports: capture the word and raise valid for each enabled port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= '0;
    end else if (state == READY) begin
      for (int i = 0; i < NRD; i++) begin
        rd_valid[i] <= rd_en[i];
        if (rd_en[i]) begin
          rd_data[i*DATA_W +: DATA_W] <= port_word[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_memoria_param.sv
// tb_memoria_param: table-driven and randomized checks of memoria_param with a
// full-depth instance and a DEPTH=1000 instance sharing clock and reset.
module tb_memoria_param;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        a_wr_en;
  logic [9:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic [1:0]  a_rd_en;
  logic [19:0] a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_valid;
  logic        a_busy;

  logic        b_wr_en;
  logic [9:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic [1:0]  b_rd_en;
  logic [19:0] b_rd_addr;
  logic [63:0] b_rd_data;
  logic [1:0]  b_rd_valid;
  logic        b_busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl_mem [1024];
  logic [31:0] mdl_d   [2];
  logic [1:0]  mdl_v;

`ifdef MEMORIA_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [9:0]  wa;
    logic [31:0] wd;
    logic [1:0]  re;
    logic [9:0]  ra0;
    logic [9:0]  ra1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  v;
  } vec_t;

  vec_t vecs [15];

  memoria_param dut_a (
    .clock(clock), .reset(reset),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .busy(a_busy)
  );

  memoria_param #(.DATA_W(32), .ADDR_W(10), .DEPTH(1000), .NRD(2)) dut_b (
    .clock(clock), .reset(reset),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .busy(b_busy)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle on instance A, advance the reference model, sample after the edge.
  task automatic applyStimulus(input logic we, input logic [9:0] wa, input logic [31:0] wd,
                               input logic [1:0] re, input logic [9:0] ra0, input logic [9:0] ra1);
    logic [9:0] ra [2];
    ra[0] = ra0;
    ra[1] = ra1;
    a_wr_en   = we;
    a_wr_addr = wa;
    a_wr_data = wd;
    a_rd_en   = re;
    a_rd_addr = {ra1, ra0};
    for (int p = 0; p < 2; p++) begin
      mdl_v[p] = re[p];
      if (re[p]) mdl_d[p] = (BYPASS && we && wa == ra[p]) ? wd : mdl_mem[ra[p]];
    end
    if (we) mdl_mem[wa] = wd;
    @(posedge clock);
    #1;
  endtask

  // Drive one cycle on instance B (DEPTH=1000) and sample after the edge.
  task automatic stepB(input logic we, input logic [9:0] wa, input logic [31:0] wd,
                       input logic [1:0] re, input logic [9:0] ra0);
    b_wr_en   = we;
    b_wr_addr = wa;
    b_wr_data = wd;
    b_rd_en   = re;
    b_rd_addr = {10'd0, ra0};
    @(posedge clock);
    #1;
  endtask

  task automatic idleInputs();
    a_wr_en = 0; a_wr_addr = 0; a_wr_data = 0; a_rd_en = 0; a_rd_addr = 0;
    b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0; b_rd_en = 0; b_rd_addr = 0;
  endtask

  task automatic clearModel();
    for (int k = 0; k < 1024; k++) mdl_mem[k] = '0;
    mdl_d[0] = '0;
    mdl_d[1] = '0;
    mdl_v    = '0;
  endtask

  // Count cycles from reset release until each busy flag drops, bounded.
  task automatic waitClear(input string tag, input logic drive_junk);
    int cyc_a, cyc_b, bad;
    cyc_a = 0; cyc_b = 0; bad = 0;
    if (drive_junk) begin
      a_wr_en = 1; a_wr_addr = 10'd5; a_wr_data = 32'd99;
      a_rd_en = 2'b11; a_rd_addr = {10'd5, 10'd5};
    end
    reset = 1'b0;
    for (int c = 1; c <= 1100 && (cyc_a == 0 || cyc_b == 0); c++) begin
      @(posedge clock);
      #1;
      if (cyc_a == 0 && !a_busy) cyc_a = c;
      if (cyc_b == 0 && !b_busy) cyc_b = c;
      if (a_busy && (a_rd_valid != 0 || a_rd_data != 0)) bad++;
    end
    idleInputs();
    checkOutput({tag, "_busy_len_a"}, 64'(cyc_a), 64'd1024);
    checkOutput({tag, "_busy_len_b"}, 64'(cyc_b), 64'd1000);
    checkOutput({tag, "_quiet_during_clear"}, 64'(bad), 64'd0);
  endtask

  initial begin
    logic [31:0] byp_val;
    logic        we;
    logic [9:0]  wa, ra0, ra1;
    logic [1:0]  re;

    byp_val = BYPASS ? 32'd256 : 32'd128;
    vecs[0] = '{1'b0, 10'd0,    32'd0,   2'b01, 10'd5,    10'd0,    32'd0,   32'd0,   2'b01};
    vecs[1] = '{1'b1, 10'd0,    32'd42,  2'b00, 10'd0,    10'd0,    32'd0,   32'd0,   2'b00};
    vecs[2] = '{1'b1, 10'd1023, 32'd128, 2'b00, 10'd0,    10'd0,    32'd0,   32'd0,   2'b00};
    vecs[3] = '{1'b0, 10'd0,    32'd0,   2'b11, 10'd0,    10'd1023, 32'd42,  32'd128, 2'b11};
    vecs[4] = '{1'b0, 10'd0,    32'd0,   2'b00, 10'd0,    10'd0,    32'd42,  32'd128, 2'b00};
    vecs[5] = '{1'b1, 10'd1023, 32'd256, 2'b01, 10'd1023, 10'd0,    byp_val, 32'd128, 2'b01};
    vecs[6] = '{1'b0, 10'd0,    32'd0,   2'b01, 10'd1023, 10'd0,    32'd256, 32'd128, 2'b01};
    for (int k = 7; k < 15; k++)
      vecs[k] = '{1'b0, 10'd0, 32'd0, 2'b11, 10'd0, 10'd0, 32'd42, 32'd42, 2'b11};

    idleInputs();
    clearModel();

    repeat (4) @(posedge clock);
    #1;
    checkOutput("reset_busy_a", 64'(a_busy), 64'd1);
    checkOutput("reset_valid_a", 64'(a_rd_valid), 64'd0);
    checkOutput("reset_data_a", a_rd_data, 64'd0);
    checkOutput("reset_busy_b", 64'(b_busy), 64'd1);

    waitClear("first", 1'b1);

    // Directed table on the full-depth instance.
    for (int k = 0; k < 15; k++) begin
      applyStimulus(vecs[k].we, vecs[k].wa, vecs[k].wd, vecs[k].re, vecs[k].ra0, vecs[k].ra1);
      checkOutput($sformatf("vec%0d_valid", k), 64'(a_rd_valid), 64'(vecs[k].v));
      checkOutput($sformatf("vec%0d_data", k), a_rd_data, {vecs[k].d1, vecs[k].d0});
    end
    idleInputs();

    // Reduced-depth instance: out-of-range write dropped, out-of-range read is zero.
    stepB(1'b1, 10'd1010, 32'd7, 2'b00, 10'd0);
    stepB(1'b1, 10'd999, 32'd55, 2'b00, 10'd0);
    stepB(1'b0, 10'd0, 32'd0, 2'b01, 10'd1010);
    checkOutput("b_oob_valid", 64'(b_rd_valid), 64'd1);
    checkOutput("b_oob_data", b_rd_data, 64'd0);
    stepB(1'b0, 10'd0, 32'd0, 2'b01, 10'd10);
    checkOutput("b_alias_data", b_rd_data, 64'd0);
    stepB(1'b0, 10'd0, 32'd0, 2'b01, 10'd999);
    checkOutput("b_last_data", b_rd_data, 64'd55);
    idleInputs();

    // Randomized traffic on a small address window plus the top word.
    for (int n = 0; n < 300; n++) begin
      we  = 1'($urandom_range(0, 1));
      re  = 2'($urandom_range(0, 3));
      wa  = ($urandom_range(0, 7) == 0) ? 10'd1023 : 10'($urandom_range(0, 15));
      ra0 = ($urandom_range(0, 7) == 0) ? 10'd1023 : 10'($urandom_range(0, 15));
      ra1 = ($urandom_range(0, 7) == 0) ? 10'd1023 : 10'($urandom_range(0, 15));
      applyStimulus(we, wa, $urandom, re, ra0, ra1);
      checkOutput($sformatf("rnd%0d_valid", n), 64'(a_rd_valid), 64'(mdl_v));
      checkOutput($sformatf("rnd%0d_data", n), a_rd_data, {mdl_d[1], mdl_d[0]});
    end

    // Reset in the middle of a read clears outputs without a clock edge.
    applyStimulus(1'b1, 10'd0, 32'd42, 2'b00, 10'd0, 10'd0);
    applyStimulus(1'b0, 10'd0, 32'd0, 2'b01, 10'd0, 10'd0);
    checkOutput("pre_reset_read", {32'd0, a_rd_data[31:0]}, 64'd42);
    #1 reset = 1'b1;
    #1;
    checkOutput("async_valid", 64'(a_rd_valid), 64'd0);
    checkOutput("async_data", a_rd_data, 64'd0);
    checkOutput("async_busy", 64'(a_busy), 64'd1);
    idleInputs();
    clearModel();
    repeat (2) @(posedge clock);
    #1;
    waitClear("second", 1'b0);
    applyStimulus(1'b0, 10'd0, 32'd0, 2'b01, 10'd0, 10'd0);
    checkOutput("after_reclear_valid", 64'(a_rd_valid), 64'd1);
    checkOutput("after_reclear_data", a_rd_data, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
